// File: rtl/calc_sequencer.sv
// calc_sequencer -- multi-cycle arithmetic controller for the FPGA calculator.
//
// Accepts one operation at a time and sequences a single 4-bit ripple adder
// (m_bit_Adder) to produce the result. ADD and SUB use one adder pass. MUL is a
// 4-iteration shift-add that accumulates into hi while the multiplier shifts
// out of lo.
//
// Build option: define CALC_SEQ_MUL_EN to enable MUL (op 10). Without it, op 10
// is rejected exactly like op 11, and the hi/cnt registers and the MUL adder
// mux are not built.
//
// Ports:
//   clk     in   system clock, rising edge
//   reset   in   synchronous, active-high reset
//   start   in   request, sampled only in IDLE
//   op      in   [1:0] 00 ADD, 01 SUB, 10 MUL, 11 reserved
//   A, B    in   [3:0] unsigned operands, latched on accepted start
//   busy    out  high whenever not IDLE
//   done    out  one-cycle pulse; result/flag/err valid while high, then held
//   result  out  [7:0] unsigned result, zero-extended
//   flag    out  ADD carry out, SUB borrow (A < B), MUL 0
//   err     out  illegal operation

module calc_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [3:0] A,
  input  logic [3:0] B,
  output logic       busy,
  output logic       done,
  output logic [7:0] result,
  output logic       flag,
  output logic       err
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

  state_t     state_q, state_d;
  logic [3:0] a_q, a_d;
  logic [3:0] lo_q, lo_d;
  logic [1:0] op_q, op_d;
  logic [7:0] result_q, result_d;
  logic       flag_q, flag_d;
  logic       err_q, err_d;
  logic       done_q, done_d;
`ifdef CALC_SEQ_MUL_EN
  logic [3:0] hi_q, hi_d;
  logic [1:0] cnt_q, cnt_d;
`endif

  logic [3:0] add_a, add_b, add_sum;
  logic       add_cin, add_cout;

  m_bit_Adder #(.M(4)) u_adder (
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (add_cin),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  // Adder operand selection; SUB is A + ~B + 1.
  always_comb begin
    add_a   = a_q;
    add_b   = lo_q;
    add_cin = 1'b0;
    case (op_q)
      2'b01: begin
        add_b   = ~lo_q;
        add_cin = 1'b1;
      end
`ifdef CALC_SEQ_MUL_EN
      2'b10: begin
        add_a = hi_q;
        add_b = lo_q[0] ? a_q : 4'd0;
      end
`endif
      default: ;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      lo_q     <= '0;
      op_q     <= '0;
      result_q <= '0;
      flag_q   <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
`ifdef CALC_SEQ_MUL_EN
      hi_q     <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      lo_q     <= lo_d;
      op_q     <= op_d;
      result_q <= result_d;
      flag_q   <= flag_d;
      err_q    <= err_d;
      done_q   <= done_d;
`ifdef CALC_SEQ_MUL_EN
      hi_q     <= hi_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_DONE;
`ifdef CALC_SEQ_MUL_EN
        if (op_q == 2'b10 && cnt_q != 2'd3) state_d = S_EXEC;
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values. done_d is raised exactly on the edge
  // that enters DONE, so done_q is high for the whole DONE cycle.
  always_comb begin
    a_d      = a_q;
    lo_d     = lo_q;
    op_d     = op_q;
    result_d = result_q;
    flag_d   = flag_q;
    err_d    = err_q;
    done_d   = 1'b0;
`ifdef CALC_SEQ_MUL_EN
    hi_d     = hi_q;
    cnt_d    = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d  = A;
          lo_d = B;
          op_d = op;
`ifdef CALC_SEQ_MUL_EN
          hi_d  = '0;
          cnt_d = '0;
`endif
        end
      end
      S_EXEC: begin
        case (op_q)
          2'b00: begin
            result_d = {3'b000, add_cout, add_sum};
            flag_d   = add_cout;
            err_d    = 1'b0;
            done_d   = 1'b1;
          end
          2'b01: begin
            result_d = {4'b0000, add_sum};
            flag_d   = ~add_cout;
            err_d    = 1'b0;
            done_d   = 1'b1;
          end
`ifdef CALC_SEQ_MUL_EN
          2'b10: begin
            // New partial product bit shifts into lo[3] as the consumed
            // multiplier bit leaves lo[0].
            {hi_d, lo_d} = {add_cout, add_sum, lo_q[3:1]};
            cnt_d        = cnt_q + 2'd1;
            if (cnt_q == 2'd3) begin
              result_d = {add_cout, add_sum, lo_q[3:1]};
              flag_d   = 1'b0;
              err_d    = 1'b0;
              done_d   = 1'b1;
            end
          end
`endif
          default: begin
            result_d = '0;
            flag_d   = 1'b0;
            err_d    = 1'b1;
            done_d   = 1'b1;
          end
        endcase
      end
      default: ;
    endcase
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign flag   = flag_q;
  assign err    = err_q;

endmodule

// m_bit_Adder -- M-bit adder with carry in and carry out.
//   a_i, b_i in [M-1:0] addends; cin_i in carry in
//   sum_o out [M-1:0] sum; cout_o out carry out
module m_bit_Adder #(
  parameter int M = 4
) (
  input  logic [M-1:0] a_i,
  input  logic [M-1:0] b_i,
  input  logic         cin_i,
  output logic [M-1:0] sum_o,
  output logic         cout_o
);
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{M{1'b0}}, cin_i};
endmodule
